// File: rtl/filo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : filo_arbiter
//  Description : Round-robin arbiter sharing one FILO stack between NUM_REQ
//                requesters. A granted request becomes a single-cycle push or
//                pop strobe to the stack. The requester then receives either
//                the popped data or an error flag. Illegal requests are
//                push-when-full and pop-when-empty. They are answered without
//                touching the stack.
//  Ports       : clk_i, reset_i          clock / synchronous active-high reset
//                req_i, op_i, din_i      per-requester request, op (1=push), data
//                gnt_o, rsp_valid_o      one-hot grant / one-hot response strobe
//                rsp_data_o, rsp_err_o   response payload / error flag
//                busy_o                  arbiter is not idle
//                stk_push_o, stk_pop_o,
//                stk_din_o               strobes and push data to the stack
//                stk_dout_i, stk_full_i,
//                stk_empty_i             pop data and status from the stack
//  Revision    : 1.0 - initial release
// ============================================================================
module filo_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ-1:0]       op_i,
   input  logic [NUM_REQ*WIDTH-1:0] din_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [NUM_REQ-1:0]       rsp_valid_o,
   output logic [WIDTH-1:0]         rsp_data_o,
   output logic                     rsp_err_o,
   output logic                     busy_o,
   output logic                     stk_push_o,
   output logic                     stk_pop_o,
   output logic [WIDTH-1:0]         stk_din_o,
   input  logic [WIDTH-1:0]         stk_dout_i,
   input  logic                     stk_full_i,
   input  logic                     stk_empty_i
);

   localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_IDX_W-1:0]   r_ptr, w_ptr_nxt;
   logic                 r_op, w_op_nxt;
   logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
   logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
   logic [WIDTH-1:0]     r_rsp_data, w_rsp_data_nxt;
   logic                 r_rsp_err, w_rsp_err_nxt;
   logic                 r_busy;
   logic                 r_push, w_push_nxt;
   logic                 r_pop, w_pop_nxt;
   logic [WIDTH-1:0]     r_stk_din, w_din_nxt;

   // Round-robin search: rotate the request vector so that bit 0 is the
   // requester at the pointer. The lowest set bit then gives the offset of
   // the winner from the pointer.
   logic [NUM_REQ-1:0]   w_req_rot;
   logic [c_IDX_W-1:0]   w_off;
   logic [c_IDX_W-1:0]   w_win;
   logic [c_IDX_W-1:0]   w_ptr_inc;
   logic                 w_sel_op;
   logic [WIDTH-1:0]     w_sel_din;

   always_comb begin
      w_req_rot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_req_rot[i] = req_i[(int'(r_ptr) + i) % NUM_REQ];
      end
   end

   always_comb begin
      w_off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_req_rot[i]) begin
            w_off = c_IDX_W'(i);
         end
      end
   end

   assign w_win     = c_IDX_W'((int'(r_ptr) + int'(w_off)) % NUM_REQ);
   assign w_ptr_inc = c_IDX_W'((int'(w_win) + 1) % NUM_REQ);
   assign w_sel_op  = op_i[w_win];
   assign w_sel_din = din_i[w_win*WIDTH +: WIDTH];

   // Next-state and next-output logic. Every output is registered, so the
   // values below appear on the ports one cycle after they are decided.
   always_comb begin
      w_state_nxt     = r_state;
      w_ptr_nxt       = r_ptr;
      w_op_nxt        = r_op;
      w_gnt_nxt       = r_gnt;
      w_rsp_valid_nxt = '0;
      w_rsp_data_nxt  = '0;
      w_rsp_err_nxt   = 1'b0;
      w_push_nxt      = 1'b0;
      w_pop_nxt       = 1'b0;
      w_din_nxt       = '0;
      case (r_state)
         S_IDLE: begin
            if (|req_i) begin
               w_ptr_nxt = w_ptr_inc;
               w_op_nxt  = w_sel_op;
               w_gnt_nxt = NUM_REQ'(1) << w_win;
               // An illegal op skips the stack and answers with an error next cycle.
               if (w_sel_op ? stk_full_i : stk_empty_i) begin
                  w_state_nxt     = S_RESP;
                  w_rsp_valid_nxt = NUM_REQ'(1) << w_win;
                  w_rsp_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_ISSUE;
                  w_push_nxt  = w_sel_op;
                  w_pop_nxt   = ~w_sel_op;
                  w_din_nxt   = w_sel_op ? w_sel_din : '0;
               end
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // Stack pop data has settled by now and is captured into the response.
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = r_gnt;
            w_rsp_data_nxt  = r_op ? '0 : stk_dout_i;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_op        <= 1'b0;
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_push      <= 1'b0;
         r_pop       <= 1'b0;
         r_stk_din   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_op        <= w_op_nxt;
         r_gnt       <= w_gnt_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_push      <= w_push_nxt;
         r_pop       <= w_pop_nxt;
         r_stk_din   <= w_din_nxt;
      end
   end

   assign gnt_o       = r_gnt;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_err_o   = r_rsp_err;
   assign busy_o      = r_busy;
   assign stk_push_o  = r_push;
   assign stk_pop_o   = r_pop;
   assign stk_din_o   = r_stk_din;

endmodule
`default_nettype wire
